// File: rtl/nkmm_prog_mem_if.sv
// Load-side bus of nkmm_prog_mem: start/end framing plus a byte-serial
// valid/ready stream from the host loader, and the load status returned to it.
// NKMM_PROG_MEM_CSUM_EN adds the running byte checksum to the bus.
interface nkmm_prog_mem_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  load_start_i;
  logic                  load_end_i;
  logic                  load_valid_i;
  logic [7:0]            load_byte_i;
  logic                  load_ready_o;
  logic [ADDR_WIDTH:0]   load_words_o;
  logic                  load_err_o;
`ifdef NKMM_PROG_MEM_CSUM_EN
  logic [7:0]            load_csum_o;
`endif

  modport master (
    output load_start_i, load_end_i, load_valid_i, load_byte_i,
    input  load_ready_o, load_words_o, load_err_o
`ifdef NKMM_PROG_MEM_CSUM_EN
    , input load_csum_o
`endif
  );

  modport slave (
    input  load_start_i, load_end_i, load_valid_i, load_byte_i,
    output load_ready_o, load_words_o, load_err_o
`ifdef NKMM_PROG_MEM_CSUM_EN
    , output load_csum_o
`endif
  );
endinterface

// File: rtl/nkmm_prog_mem.sv
// Program memory for nkmm_cpu. Serves registered instruction fetches while
// idle and accepts a big-endian byte-serial program load, holding the CPU
// for the duration of the load.
// Optional feature macro: NKMM_PROG_MEM_CSUM_EN (mod-256 load byte checksum).
module nkmm_prog_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] FILL_WORD  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        prog_addr_i,
  output logic [31:0]        prog_data_o,
  output logic               cpu_hold_o,
  nkmm_prog_mem_if.slave     load
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                state, state_d;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           word_reg, word_d;
  logic [1:0]            byte_cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] load_addr, addr_d;
  logic [ADDR_WIDTH:0]   load_words, words_d;
  logic                  load_err, err_d;
  logic                  fetch_in_range;
  logic [ADDR_WIDTH-1:0] fetch_idx;
`ifdef NKMM_PROG_MEM_CSUM_EN
  logic [7:0]            csum, csum_d;
`endif

  assign fetch_in_range    = (32'(prog_addr_i) >> ADDR_WIDTH) == 32'd0;
  assign fetch_idx         = ADDR_WIDTH'(prog_addr_i);
  assign cpu_hold_o        = (state != IDLE);
  assign load.load_ready_o = (state == LOAD);
  assign load.load_words_o = load_words;
  assign load.load_err_o   = load_err;
`ifdef NKMM_PROG_MEM_CSUM_EN
  assign load.load_csum_o  = csum;
`endif

  // Next-state and load bookkeeping; a start pulse overrides every state
  // afterwards, so a COMMIT in flight still writes while counters restart.
  always_comb begin
    state_d = state;
    word_d  = word_reg;
    cnt_d   = byte_cnt;
    addr_d  = load_addr;
    words_d = load_words;
    err_d   = load_err;
`ifdef NKMM_PROG_MEM_CSUM_EN
    csum_d  = csum;
`endif
    case (state)
      IDLE: ;
      LOAD: begin
        if (load.load_valid_i) begin
          word_d = {word_reg[23:0], load.load_byte_i};
          cnt_d  = byte_cnt + 2'd1;
`ifdef NKMM_PROG_MEM_CSUM_EN
          csum_d = csum + load.load_byte_i;
`endif
          if (byte_cnt == 2'd3) begin
            state_d = COMMIT;
          end else if (load.load_end_i) begin
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end else if (load.load_end_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (byte_cnt != 2'd0) err_d = 1'b1;
        end
      end
      COMMIT: begin
        addr_d  = load_addr + 1'b1;
        words_d = load_words + 1'b1;
        cnt_d   = '0;
        if (load_addr == '1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load.load_start_i) begin
      state_d = LOAD;
      addr_d  = '0;
      cnt_d   = '0;
      words_d = '0;
      err_d   = 1'b0;
`ifdef NKMM_PROG_MEM_CSUM_EN
      csum_d  = '0;
`endif
    end
  end

  // State and load registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_reg   <= '0;
      byte_cnt   <= '0;
      load_addr  <= '0;
      load_words <= '0;
      load_err   <= 1'b0;
`ifdef NKMM_PROG_MEM_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
      word_reg   <= word_d;
      byte_cnt   <= cnt_d;
      load_addr  <= addr_d;
      load_words <= words_d;
      load_err   <= err_d;
`ifdef NKMM_PROG_MEM_CSUM_EN
      csum       <= csum_d;
`endif
    end
  end

  // Memory write port: only COMMIT writes, and fetch reads only in IDLE.
  always_ff @(posedge clk) begin
    if (state == COMMIT) mem[load_addr] <= word_reg;
  end

  // Registered fetch; fill word while loading or for out-of-range addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prog_data_o <= FILL_WORD;
    end else if (state == IDLE && fetch_in_range) begin
      prog_data_o <= mem[fetch_idx];
    end else begin
      prog_data_o <= FILL_WORD;
    end
  end

endmodule
